// File: rtl/inst_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : inst_issuer (with package inst_issuer_pkg)
//  Purpose  : Driving end of the global-inputs bus. Holds a short program,
//             applies a machine reset sequence, then issues the program one
//             instruction per non-stalled cycle toward the receiver port.
//  Ports    : clock, reset (async, active-high), clear
//             ld_valid/ld_ready + ld_opcode/ld_imm/ld_src1/ld_src2/ld_dst
//             start, stall, [stop when INST_ISSUER_LOOP_EN is defined]
//             m_reset, m_instv, m_opcode, m_imm, m_src1, m_src2, m_dst
//             busy, done, prog_len
//  Options  : INST_ISSUER_LOOP_EN - replay the program continuously until a
//             stop request is seen during a pass.
//  Revision : 1.0 - initial release
// ============================================================================

package inst_issuer_pkg;
  typedef logic [3:0] t_opcode;
  typedef logic [7:0] t_data;
  typedef logic [2:0] t_reg_name;
endpackage

module inst_issuer
  import inst_issuer_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  t_opcode                  ld_opcode,
  input  t_data                    ld_imm,
  input  t_reg_name                ld_src1,
  input  t_reg_name                ld_src2,
  input  t_reg_name                ld_dst,
  input  logic                     start,
  input  logic                     stall,
`ifdef INST_ISSUER_LOOP_EN
  input  logic                     stop,
`endif
  output logic                     m_reset,
  output logic                     m_instv,
  output t_opcode                  m_opcode,
  output t_data                    m_imm,
  output t_reg_name                m_src1,
  output t_reg_name                m_src2,
  output t_reg_name                m_dst,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   prog_len
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PLW = AW + 1;
  localparam int CW  = $clog2(RST_CYCLES + 1);

  localparam logic [PLW-1:0] PL_ONE   = PLW'(1);
  localparam logic [PLW-1:0] PL_DEPTH = PLW'(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [CW-1:0]  CNT_INIT = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    t_opcode   opcode;
    t_data     imm;
    t_reg_name src1;
    t_reg_name src2;
    t_reg_name dst;
  } entry_t;

  entry_t           prog_mem_q [DEPTH];

  state_t           state_q, state_d;
  logic [PLW-1:0]   prog_len_q, prog_len_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             m_reset_q, m_reset_d;
  logic             m_instv_q, m_instv_d;
  entry_t           fields_q, fields_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ld_ready_q, ld_ready_d;
  logic             stop_seen_q, stop_seen_d;
  logic             wr_en;
  logic             last;

  // rd_ptr points at the final stored entry
  assign last = ({1'b0, rd_ptr_q} == (prog_len_q - PL_ONE));

  always_comb begin
    state_d     = state_q;
    prog_len_d  = prog_len_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    stop_seen_d = stop_seen_q;
    m_instv_d   = 1'b0;
    fields_d    = '0;
    done_d      = 1'b0;
    wr_en       = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // clear beats a simultaneous load
        if (clear) begin
          prog_len_d = '0;
        end else if (ld_valid && ld_ready_q) begin
          wr_en      = 1'b1;
          prog_len_d = prog_len_q + PL_ONE;
        end
        // a load in the start cycle is part of the run, so test the new length
        if (start && (prog_len_d != '0)) begin
          state_d     = S_RESET;
          cnt_d       = CNT_INIT;
          stop_seen_d = 1'b0;
        end
      end
      S_RESET: begin
        if (cnt_q == '0) begin
          state_d     = S_ISSUE;
          rd_ptr_d    = '0;
          stop_seen_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_ISSUE: begin
`ifdef INST_ISSUER_LOOP_EN
        stop_seen_d = stop_seen_q | stop;
`endif
        if (!stall) begin
          m_instv_d = 1'b1;
          fields_d  = prog_mem_q[rd_ptr_q];
          if (last) begin
            done_d = 1'b1;
`ifdef INST_ISSUER_LOOP_EN
            if (stop || stop_seen_q) begin
              state_d = S_DONE;
            end else begin
              rd_ptr_d    = '0;
              stop_seen_d = 1'b0;
            end
`else
            state_d = S_DONE;
`endif
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // DONE keeps the machine out of reset so it retains its state
    m_reset_d  = (state_d == S_IDLE) || (state_d == S_RESET);
    busy_d     = (state_d == S_RESET) || (state_d == S_ISSUE);
    ld_ready_d = ((state_d == S_IDLE) || (state_d == S_DONE)) && (prog_len_d < PL_DEPTH);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      prog_len_q  <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      m_reset_q   <= 1'b1;
      m_instv_q   <= 1'b0;
      fields_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ld_ready_q  <= 1'b0;
      stop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prog_len_q  <= prog_len_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      m_reset_q   <= m_reset_d;
      m_instv_q   <= m_instv_d;
      fields_q    <= fields_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ld_ready_q  <= ld_ready_d;
      stop_seen_q <= stop_seen_d;
    end
  end

  // Program storage carries no reset; contents are meaningless until loaded
  always_ff @(posedge clock) begin
    if (wr_en) begin
      prog_mem_q[prog_len_q[AW-1:0]] <= '{opcode: ld_opcode, imm: ld_imm,
                                          src1: ld_src1, src2: ld_src2, dst: ld_dst};
    end
  end

  assign ld_ready = ld_ready_q;
  assign m_reset  = m_reset_q;
  assign m_instv  = m_instv_q;
  assign m_opcode = fields_q.opcode;
  assign m_imm    = fields_q.imm;
  assign m_src1   = fields_q.src1;
  assign m_src2   = fields_q.src2;
  assign m_dst    = fields_q.dst;
  assign busy     = busy_q;
  assign done     = done_q;
  assign prog_len = prog_len_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_issuer
//  Purpose  : Self-checking bench for inst_issuer. A queue holds the expected
//             program; each run is checked against it cycle by cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_issuer;
  import inst_issuer_pkg::*;

  localparam int DEPTH      = 16;
  localparam int RST_CYCLES = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       ld_valid = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
`ifdef INST_ISSUER_LOOP_EN
  logic       stop = 1'b1;
`endif
  t_opcode    ld_opcode = '0;
  t_data      ld_imm = '0;
  t_reg_name  ld_src1 = '0, ld_src2 = '0, ld_dst = '0;

  logic       ld_ready, m_reset, m_instv, busy, done;
  t_opcode    m_opcode;
  t_data      m_imm;
  t_reg_name  m_src1, m_src2, m_dst;
  logic [$clog2(DEPTH):0] prog_len;

  int n_checks = 0;
  int n_errors = 0;
  logic [20:0] model [$];

  always #5 clock = ~clock;

  inst_issuer #(.DEPTH(DEPTH), .RST_CYCLES(RST_CYCLES)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_opcode(ld_opcode), .ld_imm(ld_imm),
    .ld_src1(ld_src1), .ld_src2(ld_src2), .ld_dst(ld_dst),
    .start(start), .stall(stall),
`ifdef INST_ISSUER_LOOP_EN
    .stop(stop),
`endif
    .m_reset(m_reset), .m_instv(m_instv),
    .m_opcode(m_opcode), .m_imm(m_imm),
    .m_src1(m_src1), .m_src2(m_src2), .m_dst(m_dst),
    .busy(busy), .done(done), .prog_len(prog_len)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [20:0] obs_fields();
    return {m_opcode, m_imm, m_src1, m_src2, m_dst};
  endfunction

  function automatic logic [20:0] rand_entry();
    return 21'($urandom);
  endfunction

  task automatic load_one(input logic [20:0] e);
    check_eq("ld_ready_pre", 32'(ld_ready), 32'(model.size() < DEPTH));
    {ld_opcode, ld_imm, ld_src1, ld_src2, ld_dst} = e;
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    if (model.size() < DEPTH) model.push_back(e);
    check_eq("prog_len_load", 32'(prog_len), 32'(model.size()));
  endtask

  // mode 0: no stall, 1: single stall where entry 1 would issue, 2: random stall/start
  task automatic run(input int mode, input bit ld_with_start);
    int n;
    int idx   = 0;
    int rcnt  = 0;
    int guard = 0;
    bit s;
    bit stalled = 1'b0;
    logic [20:0] e;
    if (ld_with_start) begin
      e = rand_entry();
      {ld_opcode, ld_imm, ld_src1, ld_src2, ld_dst} = e;
      ld_valid = 1'b1;
      if (model.size() < DEPTH) model.push_back(e);
    end
    n = model.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    ld_valid = 1'b0;
    check_eq("busy_start", 32'(busy), 32'd1);
    check_eq("ld_ready_busy", 32'(ld_ready), 32'd0);
    check_eq("prog_len_run", 32'(prog_len), 32'(n));
    while (m_reset === 1'b1 && rcnt < 100) begin
      rcnt++;
      check_eq("instv_in_rst", 32'(m_instv), 32'd0);
      stall = 1'($urandom);
      tick();
    end
    check_eq("rst_cycles", 32'(rcnt), 32'(RST_CYCLES));
    check_eq("instv_gap", 32'(m_instv), 32'd0);
    while (idx < n && guard < 4 * n + 20) begin
      guard++;
      case (mode)
        0:       s = 1'b0;
        1:       s = (idx == 1) && !stalled;
        default: s = ($urandom_range(0, 3) == 0);
      endcase
      if (s) stalled = 1'b1;
      stall = s;
      if (mode == 2) start = 1'($urandom_range(0, 1));
      tick();
      check_eq("instv", 32'(m_instv), 32'(!s));
      check_eq("m_reset_low", 32'(m_reset), 32'd0);
      if (!s) begin
        check_eq("fields", 32'(obs_fields()), 32'(model[idx]));
        check_eq("done", 32'(done), 32'(idx == n - 1));
        idx++;
      end else begin
        check_eq("fields_stall", 32'(obs_fields()), 32'd0);
        check_eq("done_stall", 32'(done), 32'd0);
      end
    end
    check_eq("issued_all", 32'(idx), 32'(n));
    stall = 1'b0;
    start = 1'b0;
    tick();
    check_eq("done_after", 32'(done), 32'd0);
    check_eq("busy_after", 32'(busy), 32'd0);
    check_eq("instv_after", 32'(m_instv), 32'd0);
    check_eq("m_reset_done", 32'(m_reset), 32'd0);
    check_eq("ld_ready_done", 32'(ld_ready), 32'(n < DEPTH));
    check_eq("prog_len_done", 32'(prog_len), 32'(n));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model.delete();
    check_eq("prog_len_clear", 32'(prog_len), 32'd0);
  endtask

  initial begin
    int g;
    // reset values, sampled while reset is held
    tick();
    tick();
    check_eq("rst_m_reset", 32'(m_reset), 32'd1);
    check_eq("rst_instv", 32'(m_instv), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ld_ready", 32'(ld_ready), 32'd0);
    check_eq("rst_prog_len", 32'(prog_len), 32'd0);
    check_eq("rst_fields", 32'(obs_fields()), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("idle_ld_ready", 32'(ld_ready), 32'd1);
    check_eq("idle_m_reset", 32'(m_reset), 32'd1);

    // start with an empty program is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("empty_start_busy", 32'(busy), 32'd0);
    tick();
    check_eq("empty_start_busy2", 32'(busy), 32'd0);

    // three-instruction program: plain run, single stall, then append + random run
    for (int k = 1; k <= 3; k++) load_one({4'(k), 8'(16 * k), 9'($urandom)});
    run(0, 1'b0);
    run(1, 1'b0);
    load_one(rand_entry());
    run(2, 1'b0);

    // clear and load together: clear wins
    {ld_opcode, ld_imm, ld_src1, ld_src2, ld_dst} = rand_entry();
    ld_valid = 1'b1;
    do_clear();
    ld_valid = 1'b0;
    check_eq("ld_ready_cleared", 32'(ld_ready), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("cleared_start_busy", 32'(busy), 32'd0);
    tick();
    check_eq("cleared_start_busy2", 32'(busy), 32'd0);
    check_eq("cleared_m_reset", 32'(m_reset), 32'd0);

    // start with a simultaneous load runs the new entry
    run(0, 1'b1);

    // fill the buffer, one attempt past full, then a random run
    do_clear();
    for (int k = 0; k <= DEPTH; k++) load_one(rand_entry());
    run(2, 1'b0);

    // asynchronous reset in the middle of issue
    do_clear();
    for (int k = 0; k < 3; k++) load_one(rand_entry());
    start = 1'b1;
    tick();
    start = 1'b0;
    g = 0;
    while (m_instv !== 1'b1 && g < 20) begin
      g++;
      tick();
    end
    check_eq("async_saw_instv", 32'(m_instv), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_instv", 32'(m_instv), 32'd0);
    check_eq("async_m_reset", 32'(m_reset), 32'd1);
    check_eq("async_busy", 32'(busy), 32'd0);
    check_eq("async_prog_len", 32'(prog_len), 32'd0);
    model.delete();
    tick();
    reset = 1'b0;
    tick();
    check_eq("post_rst_ld_ready", 32'(ld_ready), 32'd1);
    check_eq("post_rst_prog_len", 32'(prog_len), 32'd0);

`ifdef INST_ISSUER_LOOP_EN
    begin
      t_opcode seq [$];
      int dones = 0;
      bit pulsed = 1'b0;
      load_one({4'd5, 17'($urandom)});
      load_one({4'd6, 17'($urandom)});
      stop = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      g = 0;
      while (m_reset === 1'b1 && g < 20) begin
        g++;
        tick();
      end
      for (int c = 0; c < 14; c++) begin
        tick();
        if (m_instv) seq.push_back(m_opcode);
        if (done) dones++;
        if (seq.size() == 4 && !pulsed) begin
          stop = 1'b1;
          pulsed = 1'b1;
        end else begin
          stop = 1'b0;
        end
      end
      check_eq("loop_issues", 32'(seq.size()), 32'd6);
      for (int i = 0; i < seq.size() && i < 6; i++)
        check_eq("loop_seq", 32'(seq[i]), (i % 2) ? 32'd6 : 32'd5);
      check_eq("loop_dones", 32'(dones), 32'd3);
      check_eq("loop_busy_end", 32'(busy), 32'd0);
      stop = 1'b1;
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_issuer.md
Name: inst_issuer

Overview:
- Driving end of the global-inputs bus. Stores a short program, applies a machine reset sequence, then issues the program one instruction per enabled cycle on reset/instv/opcode/imm/src1/src2/dst toward the microcontroller's receiver port.
- Serves as the on-chip program source for stand-alone runs and as a bench-replaceable stimulus master.

Parameters:
- DEPTH, 16, program buffer entries; power of two, minimum 2.
- RST_CYCLES, 2, number of cycles m_reset is held high before the first issue; minimum 1.
- Field widths are $bits(t_opcode), $bits(t_data) and $bits(t_reg_name) from the shared package. They are not parameters.

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high block reset
- clear  in  1  synchronous; empties the program buffer (prog_len<=0), honoured only in IDLE or DONE
- ld_valid  in  1  load request
- ld_ready  out  1  load accept
- ld_opcode  in  t_opcode  instruction field to store
- ld_imm  in  t_data  instruction field to store
- ld_src1  in  t_reg_name  instruction field to store
- ld_src2  in  t_reg_name  instruction field to store
- ld_dst  in  t_reg_name  instruction field to store
- start  in  1  single-cycle pulse; begins a run
- stall  in  1  holds issue while high
- m_reset  out  1  machine reset
- m_instv  out  1  instruction valid
- m_opcode  out  t_opcode  instruction field driven to the machine
- m_imm  out  t_data  instruction field driven to the machine
- m_src1  out  t_reg_name  instruction field driven to the machine
- m_src2  out  t_reg_name  instruction field driven to the machine
- m_dst  out  t_reg_name  instruction field driven to the machine
- busy  out  1  high in RESET and ISSUE
- done  out  1  single-cycle pulse when the last instruction issues
- prog_len  out  $clog2(DEPTH)+1  number of stored instructions

Behaviour:
- One clock. Reset is asynchronous and active-high; the ports are named clock and reset.
- All outputs are registered.

Reset values:
- State IDLE.
- prog_len=0, rd_ptr=0.
- m_reset=1, m_instv=0, all m_* fields=0.
- busy=0, done=0, ld_ready=0.
- Buffer contents are don't-care.

States:
- IDLE
  - m_reset=1, ld_ready = (prog_len<DEPTH).
  - A load handshake (ld_valid&&ld_ready) writes the fields to buf[prog_len] and increments prog_len.
  - start with prog_len>0 -> RESET, counter=RST_CYCLES-1.
  - start with prog_len==0 is ignored.
- RESET
  - m_reset=1, ld_ready=0.
  - Counter decrements each cycle; at 0 -> ISSUE with rd_ptr=0. m_reset falls on the ISSUE entry edge.
- ISSUE
  - m_reset=0, ld_ready=0.
  - Each cycle with !stall: m_instv=1, the fields come from buf[rd_ptr], rd_ptr increments.
  - Each cycle with stall: m_instv=0, fields=0, rd_ptr holds.
  - The first instruction appears the cycle after m_reset falls if stall is low.
  - Issuing entry prog_len-1 pulses done in the same cycle as that instruction's m_instv, then -> DONE.
- DONE
  - m_reset=0 (the machine keeps its state), m_instv=0, ld_ready as in IDLE.
  - Loads append after the existing program.
  - start -> RESET; the program replays from entry 0.

Boundary conditions:
- Buffer full: ld_ready=0. ld_valid is ignored and nothing is overwritten.
- clear and a load in the same cycle: clear wins; prog_len=0 and the load is not accepted.
- start and ld_valid in the same cycle in IDLE/DONE: the load is accepted first, and the run includes it.
- start while busy is ignored; stall in RESET has no effect.
- Asynchronous reset mid-run returns everything to reset values immediately; the program is lost (prog_len=0).
- m_instv is never high while m_reset is high.
- rd_ptr never reaches prog_len during ISSUE without looping.

Optional Feature:
- Macro: INST_ISSUER_LOOP_EN.
- Defined:
  - Adds input stop (1 bit).
  - After entry prog_len-1, rd_ptr wraps to 0 and issue continues. done pulses on each wrap.
  - DONE is entered only after the instruction at entry prog_len-1 issues with stop high, or stop was seen high at any earlier cycle of the current pass (sticky).
- Undefined: no stop port; single pass as above.

Test Plan:
- Load 3 instructions (opcode 1,2,3; imm 0x10,0x20,0x30), start, RST_CYCLES=2, stall=0 -> m_reset high for 2 cycles after start; m_instv high exactly 3 consecutive cycles in order; done coincides with the 3rd; state DONE; prog_len=3.
- Same program, stall high on the cycle entry 1 would issue -> m_instv pattern 1,0,1,1; no entry duplicated or skipped; fields=0 during the stall cycle.
- Load DEPTH=16 entries, then assert ld_valid again -> ld_ready=0 on the 17th attempt; prog_len=16; the run issues 16 instructions.
- After DONE: load 1 more, then start -> replay of 4 instructions preceded by a fresh 2-cycle m_reset; clear in DONE -> prog_len=0 and a following start is ignored.
- Assert reset asynchronously during ISSUE after 1 instruction -> m_instv=0 and m_reset=1 the same instant without a clock edge; prog_len=0; ld_ready=1 the first cycle after reset drops.
- With INST_ISSUER_LOOP_EN, 2-entry program, stop raised during the 3rd pass -> issue sequence 0,1,0,1,0,1 and done pulses 3 times; DONE entered after the 3rd pass.
